// File: rtl/sram_lsu.sv
// sram_lsu: single-outstanding load/store unit driving a falling-edge-write SRAM
module sram_lsu #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic [3:0]        mem_w_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t            state, state_nxt;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              fault;
  logic              accept;
  logic [31:0]       load_data;
  assign accept = state == IDLE && req_valid;
  assign fault = (req_we ? req_funct3 > 3'd2 : !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
              || (req_funct3[1:0] == 2'd1 && req_addr[0])
              || (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0)
              || (req_addr >> ADDR_W) != 32'd0;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  // next state, handshakes and byte enables; reset gates enables so no write lands in the reset cycle
  always_comb begin
    state_nxt  = state;
    req_ready  = state == IDLE;
    resp_valid = state == RESP;
    mem_w_en   = 4'b0000;
    if (accept) state_nxt = fault ? RESP : ACCESS;
    else if (state == ACCESS) state_nxt = RESP;
    else if (state == RESP && resp_ready) state_nxt = IDLE;
    if (!rst && state == ACCESS && we_q)
      mem_w_en = f3_q[1:0] == 2'd0 ? 4'b0001 : f3_q[1:0] == 2'd1 ? 4'b0011 : 4'b1111;
  end
  // width and sign extension of the SRAM read word
  always_comb begin
    load_data = f3_q == 3'b000 ? {{24{mem_read_data[7]}}, mem_read_data[7:0]}
              : f3_q == 3'b001 ? {{16{mem_read_data[15]}}, mem_read_data[15:0]}
              : f3_q == 3'b100 ? {24'd0, mem_read_data[7:0]}
              : f3_q == 3'b101 ? {16'd0, mem_read_data[15:0]}
              : mem_read_data;
  end
  // state, latched request and registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      f3_q       <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      resp_rdata <= 32'd0;
      resp_fault <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_q       <= req_we;
        f3_q       <= req_funct3;
        addr_q     <= req_addr[ADDR_W-1:0];
        wdata_q    <= req_wdata;
        resp_rdata <= 32'd0;
        resp_fault <= fault;
      end
      if (state == ACCESS) resp_rdata <= we_q ? 32'd0 : load_data;
    end
  end
endmodule

// File: tb/tb_sram_lsu.sv
// tb_sram_lsu: randomized and directed checks of sram_lsu against a byte-array reference model
module tb_sram_lsu;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [3:0]  mem_w_en;
  logic [15:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic [7:0]  sram    [0:65535];
  logic [7:0]  ref_mem [0:65535];
  int          n_checks = 0;
  int          n_fail = 0;

  sram_lsu #(.ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .mem_w_en(mem_w_en), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  assign mem_read_data = {sram[mem_address + 16'd3], sram[mem_address + 16'd2],
                          sram[mem_address + 16'd1], sram[mem_address]};

  always @(negedge clk)
    for (int k = 0; k < 4; k++)
      if (mem_w_en[k]) sram[mem_address + 16'(k)] <= mem_write_data[8*k +: 8];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [15:0] b;
    b = a[15:0];
    return {ref_mem[b + 16'd3], ref_mem[b + 16'd2], ref_mem[b + 16'd1], ref_mem[b]};
  endfunction

  function automatic logic [31:0] sram_word(input logic [31:0] a);
    logic [15:0] b;
    b = a[15:0];
    return {sram[b + 16'd3], sram[b + 16'd2], sram[b + 16'd1], sram[b]};
  endfunction

  function automatic logic model_fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int  sz;
    logic ok;
    sz = 1 << f3[1:0];
    ok = we ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    return !ok || (a % 32'(sz)) != 32'd0 || a >= 32'h0001_0000;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w;
    w = ref_word(a);
    if (f3 == 3'd0) return 32'($signed(w[7:0]));
    if (f3 == 3'd1) return 32'($signed(w[15:0]));
    if (f3 == 3'd4) return {24'd0, w[7:0]};
    if (f3 == 3'd5) return {16'd0, w[15:0]};
    return w;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    for (int k = 0; k < (1 << f3[1:0]); k++) ref_mem[a[15:0] + 16'(k)] = wd[8*k +: 8];
  endtask

  // Drives one request from IDLE and completes its response; reports what the DUT did.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic flt, output int lat,
                       output int wen_cyc, output logic [3:0] wen_val);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; wen_cyc = 0; wen_val = 4'd0;
    while (!resp_valid && lat < 20) begin
      if (mem_w_en != 4'd0) begin wen_cyc++; wen_val = mem_w_en; end
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata; flt = resp_fault;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (mem_w_en !== 4'd0) begin n_fail++; $display("FAIL reset_wen_in_reset: got %b expected 0000", mem_w_en); end
    rst = 1'b0;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    n_checks++; if (resp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_resp_rdata: got %h expected 0", resp_rdata); end
    n_checks++; if (resp_fault !== 1'b0) begin n_fail++; $display("FAIL reset_resp_fault: got %b expected 0", resp_fault); end
    n_checks++; if (mem_address !== 16'd0) begin n_fail++; $display("FAIL reset_mem_address: got %h expected 0", mem_address); end
    n_checks++; if (mem_write_data !== 32'd0) begin n_fail++; $display("FAIL reset_mem_write_data: got %h expected 0", mem_write_data); end
  endtask

  task automatic test_sw_lw;
    logic [31:0] rd; logic flt; int lat, wc; logic [3:0] wv;
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, flt, lat, wc, wv);
    ref_store(3'b010, 32'h10, 32'hDEADBEEF);
    n_checks++; if (wc !== 1 || wv !== 4'b1111) begin n_fail++; $display("FAIL sw_wen: got %0d cycles of %b expected 1 cycle of 1111", wc, wv); end
    n_checks++; if (flt !== 1'b0 || rd !== 32'd0) begin n_fail++; $display("FAIL sw_resp: got fault %b rdata %h expected 0/0", flt, rd); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL sw_latency: got %0d expected 2", lat); end
    issue(1'b0, 3'b010, 32'h10, 32'd0, rd, flt, lat, wc, wv);
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_rdata: got %h expected deadbeef", rd); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL lw_latency: got %0d expected 2", lat); end
    n_checks++; if (wc !== 0) begin n_fail++; $display("FAIL lw_wen: got %0d write cycles expected 0", wc); end
  endtask

  task automatic test_byte;
    logic [31:0] rd; logic flt; int lat, wc; logic [3:0] wv;
    issue(1'b1, 3'b000, 32'h21, 32'h80, rd, flt, lat, wc, wv);
    ref_store(3'b000, 32'h21, 32'h80);
    n_checks++; if (wc !== 1 || wv !== 4'b0001) begin n_fail++; $display("FAIL sb_wen: got %0d cycles of %b expected 1 cycle of 0001", wc, wv); end
    issue(1'b0, 3'b000, 32'h21, 32'd0, rd, flt, lat, wc, wv);
    n_checks++; if (rd !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_rdata: got %h expected ffffff80", rd); end
    issue(1'b0, 3'b100, 32'h21, 32'd0, rd, flt, lat, wc, wv);
    n_checks++; if (rd !== 32'h00000080) begin n_fail++; $display("FAIL lbu_rdata: got %h expected 00000080", rd); end
    issue(1'b1, 3'b001, 32'h22, 32'h0000_8001, rd, flt, lat, wc, wv);
    ref_store(3'b001, 32'h22, 32'h0000_8001);
    n_checks++; if (wc !== 1 || wv !== 4'b0011) begin n_fail++; $display("FAIL sh_wen: got %0d cycles of %b expected 1 cycle of 0011", wc, wv); end
    issue(1'b0, 3'b001, 32'h22, 32'd0, rd, flt, lat, wc, wv);
    n_checks++; if (rd !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh_rdata: got %h expected ffff8001", rd); end
  endtask

  task automatic test_misaligned;
    logic [31:0] rd; logic flt; int lat, wc; logic [3:0] wv;
    issue(1'b1, 3'b001, 32'h31, 32'h0000_ABCD, rd, flt, lat, wc, wv);
    n_checks++; if (flt !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL sh_misaligned_resp: got fault %b rdata %h expected 1/0", flt, rd); end
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL sh_misaligned_latency: got %0d expected 1", lat); end
    n_checks++; if (wc !== 0) begin n_fail++; $display("FAIL sh_misaligned_wen: got %0d write cycles expected 0", wc); end
    n_checks++; if (sram_word(32'h30) !== ref_word(32'h30)) begin n_fail++; $display("FAIL sh_misaligned_mem: got %h expected %h", sram_word(32'h30), ref_word(32'h30)); end
  endtask

  task automatic test_upper_bits;
    logic [31:0] rd; logic flt; int lat, wc; logic [3:0] wv;
    issue(1'b0, 3'b010, 32'h0001_0000, 32'd0, rd, flt, lat, wc, wv);
    n_checks++; if (flt !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL lw_upper_bits: got fault %b rdata %h expected 1/0", flt, rd); end
    issue(1'b0, 3'b011, 32'h10, 32'd0, rd, flt, lat, wc, wv);
    n_checks++; if (flt !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL load_f3_011: got fault %b rdata %h expected 1/0", flt, rd); end
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL load_f3_011_latency: got %0d expected 1", lat); end
  endtask

  task automatic test_backpressure;
    logic [31:0] exp_rd;
    int lat;
    exp_rd = model_load(3'b010, 32'h10);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'd0;
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 32'h50; req_wdata = 32'hCAFEF00D;
    lat = 1;
    while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL bp_latency: got %0d expected 2", lat); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_resp_valid[%0d]: got %b expected 1", i, resp_valid); end
      n_checks++; if (resp_rdata !== exp_rd) begin n_fail++; $display("FAIL bp_resp_rdata[%0d]: got %h expected %h", i, resp_rdata, exp_rd); end
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready[%0d]: got %b expected 0", i, req_ready); end
      n_checks++; if (mem_w_en !== 4'd0) begin n_fail++; $display("FAIL bp_wen[%0d]: got %b expected 0000", i, mem_w_en); end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got ready %b valid %b expected 1/0", req_ready, resp_valid); end
    @(posedge clk); #1;
    n_checks++; if (sram_word(32'h50) !== ref_word(32'h50)) begin n_fail++; $display("FAIL bp_mem_0x50: got %h expected %h", sram_word(32'h50), ref_word(32'h50)); end
  endtask

  task automatic test_reset_in_access;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_checks++; if (mem_w_en !== 4'b1111) begin n_fail++; $display("FAIL rst_access_pre_wen: got %b expected 1111", mem_w_en); end
    rst = 1'b1;
    #1;
    n_checks++; if (mem_w_en !== 4'd0) begin n_fail++; $display("FAIL rst_access_wen: got %b expected 0000", mem_w_en); end
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_access_state: got ready %b valid %b expected 1/0", req_ready, resp_valid); end
    n_checks++; if (mem_address !== 16'd0) begin n_fail++; $display("FAIL rst_access_addr: got %h expected 0", mem_address); end
    n_checks++; if (sram_word(32'h40) !== ref_word(32'h40)) begin n_fail++; $display("FAIL rst_access_mem: got %h expected %h", sram_word(32'h40), ref_word(32'h40)); end
  endtask

  task automatic test_random;
    logic [31:0] rd, a, wd, exp_rd; logic flt, we, exp_flt; logic [2:0] f3; int lat, wc; logic [3:0] wv;
    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a = 32'h100 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a = a | (32'h1 << (16 + $urandom_range(0, 15)));
      wd = $urandom;
      exp_flt = model_fault(we, f3, a);
      exp_rd = (exp_flt || we) ? 32'd0 : model_load(f3, a);
      issue(we, f3, a, wd, rd, flt, lat, wc, wv);
      if (!exp_flt && we) ref_store(f3, a, wd);
      n_checks++; if (flt !== exp_flt) begin n_fail++; $display("FAIL rand_fault[%0d] we=%b f3=%b a=%h: got %b expected %b", i, we, f3, a, flt, exp_flt); end
      n_checks++; if (rd !== exp_rd) begin n_fail++; $display("FAIL rand_rdata[%0d] we=%b f3=%b a=%h: got %h expected %h", i, we, f3, a, rd, exp_rd); end
      n_checks++; if (lat !== (exp_flt ? 1 : 2)) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, exp_flt ? 1 : 2); end
      n_checks++; if (wc !== ((!exp_flt && we) ? 1 : 0)) begin n_fail++; $display("FAIL rand_wen_cycles[%0d]: got %0d expected %0d", i, wc, (!exp_flt && we) ? 1 : 0); end
    end
  endtask

  task automatic test_mem_image;
    int bad;
    bad = 0;
    for (int i = 0; i < 65536; i++) if (sram[i] !== ref_mem[i]) bad++;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL mem_image: got %0d differing bytes expected 0", bad); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      sram[i] = 8'($urandom);
      ref_mem[i] = sram[i];
    end
    #1;
    test_reset;
    test_sw_lw;
    test_byte;
    test_misaligned;
    test_upper_bits;
    test_backpressure;
    test_reset_in_access;
    test_random;
    test_mem_image;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_lsu.md
SRAM_LSU -- requirements
Module: sram_lsu

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, giving the SRAM byte-address width.
REQ-002 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit wide: reset, synchronous and active-high.
REQ-004 Port req_valid SHALL be an input, 1 bit wide: a request is present.
REQ-005 Port req_ready SHALL be an output, 1 bit wide: the block can accept a request.
REQ-006 Port req_we SHALL be an input, 1 bit wide: 1 = store, 0 = load.
REQ-007 Port req_funct3 SHALL be an input, 3 bits wide: RISC-V width and sign encoding of the access.
REQ-008 Port req_addr SHALL be an input, 32 bits wide: byte address.
REQ-009 Port req_wdata SHALL be an input, 32 bits wide: store data, right-aligned.
REQ-010 Port resp_valid SHALL be an output, 1 bit wide: a response is present.
REQ-011 Port resp_ready SHALL be an input, 1 bit wide: the consumer accepts the response.
REQ-012 Port resp_rdata SHALL be an output, 32 bits wide: load result, extended to 32 bits.
REQ-013 Port resp_fault SHALL be an output, 1 bit wide: the access was rejected.
REQ-014 Port mem_w_en SHALL be an output, 4 bits wide: per-byte write enables to the SRAM, which writes on the falling edge.
REQ-015 Port mem_address SHALL be an output, ADDR_W bits wide: SRAM byte address.
REQ-016 Port mem_write_data SHALL be an output, 32 bits wide: SRAM write data.
REQ-017 Port mem_read_data SHALL be an input, 32 bits wide: combinational SRAM read data; byte k is the byte at address+k.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on a rising edge where req_valid and req_ready are both 1.
REQ-020 On acceptance, the block SHALL latch we, funct3, addr and wdata into internal registers; the output ports SHALL be driven only from these registers, never directly from the req_* inputs.
REQ-021 The block SHALL flag a fault at acceptance for any of these cases: funct3 is not one of {000,001,010,100,101} for a load; funct3 is not one of {000,001,010} for a store; a halfword access has addr[0]=1; a word access has addr[1:0]!=00; or addr[31:ADDR_W] is nonzero.
REQ-022 On acceptance, the next state SHALL be RESP if the request faulted, otherwise ACCESS.
REQ-023 In ACCESS, mem_address SHALL equal the latched addr[ADDR_W-1:0], and mem_write_data SHALL equal the latched wdata unshifted.
REQ-024 In ACCESS with a store, mem_w_en SHALL be 0001 for SB, 0011 for SH and 1111 for SW; in every other state, for loads, and for faulted requests, mem_w_en SHALL be 0000.
REQ-025 ACCESS SHALL last exactly one cycle; at its closing rising edge the block SHALL register resp_rdata and enter RESP.
REQ-026 Load extension into resp_rdata: LB sign-extends mem_read_data[7:0]; LH sign-extends [15:0]; LW passes [31:0]; LBU zero-extends [7:0]; LHU zero-extends [15:0].
REQ-027 For stores, resp_rdata SHALL be 0 and resp_fault SHALL be 0.
REQ-028 A faulted request SHALL produce resp_rdata = 0 and resp_fault = 1, and SHALL cause no SRAM write.
REQ-029 In RESP, resp_valid SHALL be 1, with resp_rdata and resp_fault held stable until resp_ready is 1.
REQ-030 On a rising edge in RESP with resp_ready = 1, the next state SHALL be IDLE.
REQ-031 Latency: for a request accepted at edge N, a non-faulted access SHALL show resp_valid = 1 after edge N+1, and a faulted access after edge N.
REQ-032 Peak throughput SHALL be one access per 3 cycles (one per 2 cycles for faulted accesses).
REQ-033 While the block is not in IDLE, req_valid SHALL be ignored, and no request SHALL be queued.

Reset
REQ-034 While rst = 1, mem_w_en SHALL be forced to 0000 combinationally, so that no falling-edge write occurs in the reset cycle even if the state is ACCESS.
REQ-035 At a rising edge with rst = 1, the state SHALL become IDLE and all of the following SHALL be cleared to 0: resp_valid, resp_rdata, resp_fault and the latched request registers.
REQ-036 After reset, req_ready SHALL equal 1, and mem_address and mem_write_data SHALL equal 0.
REQ-037 A reset asserted in ACCESS or RESP SHALL abandon the in-flight access with no response issued.

Verification
REQ-038 The bench SHALL check: SW addr 0x0010, data 0xDEADBEEF, then LW 0x0010 -> mem_w_en=1111 for exactly one cycle, and the load response is 0xDEADBEEF after 2 cycles.
REQ-039 The bench SHALL check: SB addr 0x0021, data 0x00000080, then LB 0x0021 and LBU 0x0021 -> responses 0xFFFFFF80 and 0x00000080.
REQ-040 The bench SHALL check: SH addr 0x0031 -> resp_fault=1 one cycle after acceptance, mem_w_en stays 0000, and the memory is unchanged.
REQ-041 The bench SHALL check: LW addr 0x00010000 (upper bits set) and a load with funct3=011 -> resp_fault=1 and resp_rdata=0.
REQ-042 The bench SHALL check: resp_ready held 0 for 5 cycles in RESP -> resp_valid and resp_rdata stay stable, req_ready=0, and a second req_valid is not accepted.
REQ-043 The bench SHALL check: rst pulsed during ACCESS of SW 0x0040 -> mem_w_en=0000 in that cycle, the memory at 0x0040 is unchanged, and req_ready=1 on the next cycle.
